// File: rtl/seq_detect_param.sv
// Parameterised sequence detector: matches a runtime-loadable DEPTH-symbol pattern
// on a valid-qualified WIDTH-bit stream. Optional SEQ_MASK_EN adds per-slot don't-care.
module seq_slot_cmp #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] sym,
  input  logic [WIDTH-1:0] pat,
  input  logic             dont_care,
  output logic             hit
);
  assign hit = dont_care || (sym == pat);
endmodule

module seq_detect_param #(
  parameter int                     WIDTH    = 2,
  parameter int                     DEPTH    = 4,
  parameter int                     CNT_W    = 8,
  parameter logic [WIDTH*DEPTH-1:0] PAT_INIT = 8'hB7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_sym,
  input  logic                   overlap_en,
  input  logic                   pat_load,
  input  logic [WIDTH*DEPTH-1:0] pat_data,
`ifdef SEQ_MASK_EN
  input  logic [DEPTH-1:0]       pat_mask,
`endif
  input  logic                   cnt_clr,
  output logic                   match,
  output logic [CNT_W-1:0]       match_cnt
);
  localparam int FW = $clog2(DEPTH + 1);

  // Slot DEPTH-1 holds the newest symbol, slot 0 the oldest.
  logic [DEPTH-1:0][WIDTH-1:0] hist, pat, win;
  logic [DEPTH-1:0]            mask, slot_hit;
  logic [FW-1:0]               fill;
  logic                        hit;

  assign win = {in_sym, hist[DEPTH-1:1]};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    seq_slot_cmp #(.WIDTH(WIDTH)) u_cmp (
      .sym      (win[gi]),
      .pat      (pat[gi]),
      .dont_care(mask[gi]),
      .hit      (slot_hit[gi])
    );
  end

  assign hit = in_valid && !pat_load && (fill >= FW'(DEPTH - 1)) && (&slot_hit);

`ifdef SEQ_MASK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        mask <= '0;
    else if (pat_load) mask <= pat_mask;
  end
`else
  assign mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist      <= '0;
      pat       <= PAT_INIT;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= 1'b0;
      if (pat_load) begin
        pat  <= pat_data;
        fill <= '0;
      end else if (in_valid) begin
        hist <= win;
        if (hit) begin
          match <= 1'b1;
          // Non-overlapping mode restarts the fill so the old window cannot contribute.
          fill  <= overlap_en ? FW'(DEPTH) : '0;
        end else if (fill != FW'(DEPTH)) begin
          fill <= fill + FW'(1);
        end
      end
      if (cnt_clr)  match_cnt <= '0;
      else if (hit) match_cnt <= match_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_seq_detect_param.sv
// Table-driven scoreboard bench for seq_detect_param (default and CNT_W=2 instances).
module tb_seq_detect_param;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, overlap_en, pat_load, cnt_clr;
  logic [1:0] in_sym;
  logic [7:0] pat_data;
  logic [3:0] pat_mask;
  logic       match, match2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  always #5 clk = ~clk;

  seq_detect_param u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_data(pat_data),
`ifdef SEQ_MASK_EN
    .pat_mask(pat_mask),
`endif
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt)
  );

  seq_detect_param #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_data(pat_data),
`ifdef SEQ_MASK_EN
    .pat_mask(pat_mask),
`endif
    .cnt_clr(cnt_clr), .match(match2), .match_cnt(match_cnt2)
  );

  typedef struct {
    logic       rst_n, v;
    logic [1:0] sym;
    logic       ovl, ld;
    logic [7:0] pd;
    logic [3:0] pm;
    logic       clr, em;
    logic [7:0] ec;
  } vec_t;

  typedef struct {
    logic       em;
    logic [7:0] ec;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic r, logic v, logic [1:0] s, logic o, logic l,
                              logic [7:0] pd, logic [3:0] pm, logic c, logic em, logic [7:0] ec);
    vec_t t;
    t.rst_n = r; t.v = v; t.sym = s; t.ovl = o; t.ld = l;
    t.pd = pd; t.pm = pm; t.clr = c; t.em = em; t.ec = ec;
    return t;
  endfunction

  function automatic vec_t acc(logic [1:0] s, logic o, logic em, logic [7:0] ec);
    return mk(1'b1, 1'b1, s, o, 1'b0, 8'h00, 4'h0, 1'b0, em, ec);
  endfunction

  function automatic vec_t idle(logic [7:0] ec);
    return mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, ec);
  endfunction

  function automatic vec_t ld(logic [7:0] pd, logic [3:0] pm, logic c, logic [7:0] ec);
    return mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, pd, pm, c, 1'b0, ec);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t t, string name);
    exp_t e;
    @(negedge clk);
    rst_n = t.rst_n; in_valid = t.v; in_sym = t.sym; overlap_en = t.ovl;
    pat_load = t.ld; pat_data = t.pd; pat_mask = t.pm; cnt_clr = t.clr;
    e.em = t.em; e.ec = t.ec; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, ".match"},  {7'd0, match},  {7'd0, e.em});
    check({e.name, ".cnt"},    match_cnt,      e.ec);
    check({e.name, ".match2"}, {7'd0, match2}, {7'd0, e.em});
    check({e.name, ".cnt2"},   {6'd0, match_cnt2}, {6'd0, e.ec[1:0]});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sym = '0; overlap_en = 1'b1;
    pat_load = 1'b0; pat_data = '0; pat_mask = '0; cnt_clr = 1'b0;

    // reset
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'd0));
    // default pattern 11,01,11,10 after a leading 00
    vecs.push_back(acc(2'd0, 1, 0, 0));
    vecs.push_back(acc(2'd3, 1, 0, 0));
    vecs.push_back(acc(2'd1, 1, 0, 0));
    vecs.push_back(acc(2'd3, 1, 0, 0));
    vecs.push_back(acc(2'd2, 1, 1, 1));
    vecs.push_back(idle(1));
    // all-ones pattern, overlapping: hits on 4,5,6
    vecs.push_back(ld(8'hFF, 4'h0, 1, 0));
    for (int i = 1; i <= 6; i++) vecs.push_back(acc(2'd3, 1, i >= 4, (i >= 4) ? 8'(i - 3) : 8'd0));
    // non-overlapping: hits on 4 and 8
    vecs.push_back(ld(8'hFF, 4'h0, 1, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(acc(2'd3, 0, (i == 4) || (i == 8), (i >= 8) ? 8'd2 : (i >= 4) ? 8'd1 : 8'd0));
    // gaps between symbols
    vecs.push_back(ld(8'hB7, 4'h0, 1, 0));
    vecs.push_back(acc(2'd3, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle(0));
    vecs.push_back(acc(2'd1, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle(0));
    vecs.push_back(acc(2'd3, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(idle(0));
    vecs.push_back(acc(2'd2, 1, 1, 1));
    vecs.push_back(idle(1));
    // counter wrap on the CNT_W=2 instance, then clear together with a hit
    vecs.push_back(ld(8'hFF, 4'h0, 1, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(acc(2'd3, 1, i >= 4, (i >= 4) ? 8'(i - 3) : 8'd0));
    vecs.push_back(mk(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'd0));
    vecs.push_back(acc(2'd3, 1, 1, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // pat_load after a partial pattern discards it, and same-edge in_valid is ignored
    apply(ld(8'hB7, 4'h0, 1, 0), "reload");
    apply(acc(2'd3, 1, 0, 0), "p5a");
    apply(acc(2'd1, 1, 0, 0), "p5b");
    apply(acc(2'd3, 1, 0, 0), "p5c");
    apply(acc(2'd2, 1, 1, 1), "p5d");
    apply(acc(2'd3, 1, 0, 1), "p5e");
    apply(acc(2'd1, 1, 0, 1), "p5f");
    apply(acc(2'd3, 1, 0, 1), "p5g");
    apply(ld(8'hB7, 4'h0, 0, 1), "ld_mid");
    apply(acc(2'd2, 1, 0, 1), "after_ld");
    apply(mk(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 8'hB7, 4'h0, 1'b0, 1'b0, 8'd1), "ld_valid");
    apply(acc(2'd1, 1, 0, 1), "lv_a");
    apply(acc(2'd3, 1, 0, 1), "lv_b");
    apply(acc(2'd2, 1, 0, 1), "lv_c");
    // reset mid-stream discards history and fill
    apply(acc(2'd3, 1, 0, 1), "rs_a");
    apply(acc(2'd1, 1, 0, 1), "rs_b");
    apply(acc(2'd3, 1, 0, 1), "rs_c");
    apply(mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'd0), "mid_reset");
    apply(acc(2'd2, 1, 0, 0), "post_rst");
    apply(acc(2'd3, 1, 0, 0), "pr_a");
    apply(acc(2'd1, 1, 0, 0), "pr_b");
    apply(acc(2'd3, 1, 0, 0), "pr_c");
    apply(acc(2'd2, 1, 1, 1), "pr_hit");

`ifdef SEQ_MASK_EN
    apply(ld(8'hB7, 4'b0010, 1, 0), "mask_ld");
    apply(acc(2'd3, 1, 0, 0), "mk_a");
    apply(acc(2'd0, 1, 0, 0), "mk_b");
    apply(acc(2'd3, 1, 0, 0), "mk_c");
    apply(acc(2'd2, 1, 1, 1), "mk_hit");
    apply(ld(8'hB7, 4'b0010, 0, 1), "mask_ld2");
    apply(acc(2'd3, 1, 0, 1), "mn_a");
    apply(acc(2'd0, 1, 0, 1), "mn_b");
    apply(acc(2'd1, 1, 0, 1), "mn_c");
    apply(acc(2'd2, 1, 0, 1), "mn_miss");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
